// File: rtl/fsm_trace_monitor_if.sv
// Sample bus between an upstream 5-state FSM tap and the trace monitor.
// The master drives the observed code/control bit; the monitor reports lock, pulses and counters.
interface fsm_trace_monitor_if #(
    parameter int CNT_W = 8
);
    logic             valid;
    logic             a;
    logic [2:0]       code;
    logic             locked;
    logic             err;
    logic             illegal;
    logic             lap;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] lap_count;

    modport master (
        output valid, a, code,
        input  locked, err, illegal, lap, err_count, lap_count
    );

    modport slave (
        input  valid, a, code,
        output locked, err, illegal, lap, err_count, lap_count
    );
endinterface

// File: rtl/fsm_trace_monitor.sv
// Watches the state code of an upstream 5-state FSM, predicts each next code from (code, a),
// and flags mismatches, unencoded codes and completed 7 -> 2 laps.
//
// state | meaning
// IDLE  | no expectation held; waiting for a legal code to lock onto
// TRACK | expectation register holds the predicted next code
module fsm_trace_monitor #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fsm_trace_monitor_if.slave   bus
);
    typedef enum logic {IDLE, TRACK} state_t;

    state_t           state;
    logic [2:0]       expect_code;
    logic [2:0]       prev_code;
    logic             locked_q;
    logic             err_q;
    logic             illegal_q;
    logic             lap_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] lap_count_q;

    logic             legal;
    logic [2:0]       predicted;

    function automatic logic [2:0] predict(input logic [2:0] c, input logic a_bit);
        logic [2:0] n;
        n = 3'd0;
        case (c)
            3'd2:    n = 3'd4;
            3'd6:    n = 3'd7;
            3'd4:    n = a_bit ? 3'd6 : 3'd1;
            3'd7:    n = a_bit ? 3'd2 : 3'd4;
            3'd1:    n = 3'd6;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    always_comb begin
        legal     = (bus.code == 3'd2) || (bus.code == 3'd6) || (bus.code == 3'd4) ||
                    (bus.code == 3'd7) || (bus.code == 3'd1);
        predicted = predict(bus.code, bus.a);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            expect_code <= 3'd0;
            prev_code   <= 3'd0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            illegal_q   <= 1'b0;
            lap_q       <= 1'b0;
            err_count_q <= '0;
            lap_count_q <= '0;
        end else begin
            err_q     <= 1'b0;
            illegal_q <= 1'b0;
            lap_q     <= 1'b0;
            if (bus.valid) begin
                case (state)
                    IDLE: begin
                        if (legal) begin
                            state       <= TRACK;
                            locked_q    <= 1'b1;
                            expect_code <= predicted;
                            prev_code   <= bus.code;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (!legal) begin
                            illegal_q   <= 1'b1;
                            state       <= IDLE;
                            locked_q    <= 1'b0;
                            expect_code <= 3'd0;
                            prev_code   <= 3'd0;
                            if (err_count_q != '1)
                                err_count_q <= err_count_q + 1'b1;
                        end else begin
                            // Mismatches resync onto the observed code rather than dropping lock.
                            expect_code <= predicted;
                            prev_code   <= bus.code;
                            if (bus.code != expect_code) begin
                                err_q <= 1'b1;
                                if (err_count_q != '1)
                                    err_count_q <= err_count_q + 1'b1;
                            end else if (bus.code == 3'd2 && prev_code == 3'd7) begin
                                lap_q       <= 1'b1;
                                lap_count_q <= lap_count_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.illegal   = illegal_q;
    assign bus.lap       = lap_q;
    assign bus.err_count = err_count_q;
    assign bus.lap_count = lap_count_q;
endmodule
